// File: rtl/cpu_sequencer.sv
// +--------------------------------------------------------------------------+
// | cpu_sequencer: multi-cycle fetch/decode/exec/mem/wb control FSM           |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module cpu_sequencer #(
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W        = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic        dec_mem_load,
  input  logic        dec_mem_store,
  input  logic        dec_write_enable,
  input  logic        dec_jump_enable,
  input  logic [1:0]  dec_debug,
  input  logic        branch_taken,
  output logic        imem_req,
  output logic        ir_load,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        reg_we,
  output logic        pc_update,
  output logic        pc_sel_target,
  output logic [2:0]  state,
  output logic        halted,
  output logic        trap,
  output logic [31:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_TRAP   = 3'd7
  } state_e;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);
  localparam bit              TO_EN   = (MEM_TIMEOUT > 0);

  state_e           state_q, state_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [31:0]      retired_q, retired_d;
  logic             to_expired;
  logic             waiting;

  assign to_expired = TO_EN && (to_cnt_q == TO_LAST);

  always_comb begin
    state_d       = state_q;
    retired_d     = retired_q;
    imem_req      = 1'b0;
    ir_load       = 1'b0;
    dmem_req      = 1'b0;
    dmem_we       = 1'b0;
    reg_we        = 1'b0;
    pc_update     = 1'b0;
    pc_sel_target = 1'b0;
    halted        = 1'b0;
    trap          = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        // A ready arriving on the last allowed cycle still wins over the timeout.
        if (imem_ready) begin
          ir_load = 1'b1;
          state_d = S_DECODE;
        end else if (to_expired) begin
          state_d = S_TRAP;
        end
      end
      S_DECODE: begin
        case (dec_debug)
          2'b00:   state_d = S_EXEC;
          2'b01:   state_d = S_HALT;
          default: state_d = S_TRAP;
        endcase
      end
      S_EXEC: begin
        if (dec_mem_load && dec_mem_store)      state_d = S_TRAP;
        else if (dec_mem_load || dec_mem_store) state_d = S_MEM;
        else                                    state_d = S_WB;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = dec_mem_store;
        if (dmem_ready)      state_d = S_WB;
        else if (to_expired) state_d = S_TRAP;
      end
      S_WB: begin
        reg_we        = dec_write_enable;
        pc_update     = 1'b1;
        pc_sel_target = dec_jump_enable & branch_taken;
        retired_d     = retired_q + 32'd1;
        state_d       = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
        // Resuming steps over the EBREAK, so it counts as retired.
        if (start) begin
          pc_update = 1'b1;
          retired_d = retired_q + 32'd1;
          state_d   = S_FETCH;
        end
      end
      S_TRAP: begin
        trap = 1'b1;
      end
      default: begin
        state_d = S_TRAP;
      end
    endcase
  end

  // FETCH cannot go straight to MEM, so "same state again" means a wait cycle.
  assign waiting  = (state_q == S_FETCH) || (state_q == S_MEM);
  assign to_cnt_d = (waiting && (state_d == state_q)) ? (to_cnt_q + 1'b1) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      to_cnt_q  <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      to_cnt_q  <= to_cnt_d;
      retired_q <= retired_d;
    end
  end

  assign state   = state_q;
  assign retired = retired_q;

endmodule

`default_nettype wire
